// File: rtl/audio_output_stage_pkg.sv
// rtl/audio_output_stage_pkg.sv - shared types, constants and saturation helper for the audio output stage
package audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [7:0]         gain_t;

  localparam gain_t   UNITY_GAIN = 8'd128;
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  typedef struct packed {
    sample_t value;
    logic    clip;
  } sat_t;

  // Clamp a wide signed value into the 16-bit sample range, reporting whether clamping occurred
  function automatic sat_t sat16(input logic signed [24:0] x);
    sat_t r;
    if (x > 25'sd32767) begin
      r.value = SAMPLE_MAX;
      r.clip  = 1'b1;
    end else if (x < -25'sd32768) begin
      r.value = SAMPLE_MIN;
      r.clip  = 1'b1;
    end else begin
      r.value = x[15:0];
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_output_stage_if.sv
// rtl/audio_output_stage_if.sv - sample stream, gain control and meter signals of the audio output stage
interface audio_output_stage_if;
  import audio_pkg::*;

  sample_t    sample_in;
  logic       sample_valid;
  gain_t      gain_target;
  logic       mute;
  sample_t    audio_out;
  logic       audio_valid;
  logic       clip_led;
  logic [7:0] peak_level;

  modport master (
    output sample_in, sample_valid, gain_target, mute,
    input  audio_out, audio_valid, clip_led, peak_level
  );

  modport slave (
    input  sample_in, sample_valid, gain_target, mute,
    output audio_out, audio_valid, clip_led, peak_level
  );

endinterface

// File: rtl/audio_output_stage_level_meter.sv
// rtl/audio_output_stage_level_meter.sv - peak meter with hold/decay and stretched clip indicator
module level_meter
  import audio_pkg::*;
#(
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 6,
  parameter int CLIP_HOLD    = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  sample_t    audio_out,
  input  logic       audio_valid,
  input  logic       clip,
  output logic [7:0] peak_level,
  output logic       clip_led
);

  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int CLIP_W = $clog2(CLIP_HOLD + 1);

  logic [14:0]       peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CLIP_W-1:0] clip_cnt_q, clip_cnt_d;
  logic [14:0]       abs_val;
  logic [14:0]       decay;
  sample_t           neg_val;

  // Next peak/hold/clip-stretch state, advanced once per output sample
  always_comb begin
    peak_d     = peak_q;
    hold_d     = hold_q;
    clip_cnt_d = clip_cnt_q;
    neg_val    = -audio_out;
    if (audio_out == SAMPLE_MIN) begin
      abs_val = 15'h7FFF;
    end else if (audio_out[15]) begin
      abs_val = neg_val[14:0];
    end else begin
      abs_val = audio_out[14:0];
    end
    decay = peak_q >> DECAY_SHIFT;
    if (audio_valid) begin
      if (abs_val >= peak_q) begin
        peak_d = abs_val;
        hold_d = HOLD_W'(HOLD_SAMPLES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (decay == '0) begin
        // Small peaks would never shrink through the shift alone; step down by one to reach zero
        if (peak_q != '0) peak_d = peak_q - 15'd1;
      end else begin
        peak_d = peak_q - decay;
      end
      if (clip) begin
        clip_cnt_d = CLIP_W'(CLIP_HOLD);
      end else if (clip_cnt_q != '0) begin
        clip_cnt_d = clip_cnt_q - CLIP_W'(1);
      end
    end
  end

  // Meter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q     <= '0;
      hold_q     <= '0;
      clip_cnt_q <= '0;
    end else begin
      peak_q     <= peak_d;
      hold_q     <= hold_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign peak_level = peak_q[14:7];
  assign clip_led   = (clip_cnt_q != '0);

endmodule

// File: rtl/audio_output_stage.sv
// rtl/audio_output_stage.sv - gain ramp, saturation and metering; optional DC blocker via AUDIO_OUTPUT_STAGE_DC_BLOCK_EN
module audio_output_stage
  import audio_pkg::*;
#(
  parameter int RAMP_STEP    = 1,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 6,
  parameter int CLIP_HOLD    = 24000,
  parameter int DC_SHIFT     = 8
) (
  input logic                 clk,
  input logic                 reset,
  audio_output_stage_if.slave bus
);

  sample_t s1_in;
  logic    s1_valid;

`ifdef AUDIO_OUTPUT_STAGE_DC_BLOCK_EN
  sample_t            x_prev_q, x_prev_d;
  sample_t            y_prev_q, y_prev_d;
  sample_t            dc_out_q, dc_out_d;
  logic               dc_valid_q, dc_valid_d;
  logic signed [17:0] dc_sum;
  sat_t               dc_sat;

  // One-pole high-pass; 18-bit headroom, clamped back to 16 bits before the gain multiply
  always_comb begin
    x_prev_d   = x_prev_q;
    y_prev_d   = y_prev_q;
    dc_out_d   = dc_out_q;
    dc_valid_d = bus.sample_valid;
    dc_sum     = 18'(bus.sample_in) - 18'(x_prev_q) + 18'(y_prev_q) - 18'(y_prev_q >>> DC_SHIFT);
    dc_sat     = sat16({{7{dc_sum[17]}}, dc_sum});
    if (bus.sample_valid) begin
      x_prev_d = bus.sample_in;
      y_prev_d = dc_sat.value;
      dc_out_d = dc_sat.value;
    end
  end

  // DC blocker state
  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev_q   <= '0;
      y_prev_q   <= '0;
      dc_out_q   <= '0;
      dc_valid_q <= 1'b0;
    end else begin
      x_prev_q   <= x_prev_d;
      y_prev_q   <= y_prev_d;
      dc_out_q   <= dc_out_d;
      dc_valid_q <= dc_valid_d;
    end
  end

  assign s1_in    = dc_out_q;
  assign s1_valid = dc_valid_q;
`else
  assign s1_in    = bus.sample_in;
  assign s1_valid = bus.sample_valid;
`endif

  gain_t              cur_gain_q, cur_gain_d;
  gain_t              eff_target;
  logic signed [9:0]  gain_up, gain_dn, target_w;
  logic signed [24:0] prod_q, prod_d;
  logic               prod_valid_q, prod_valid_d;
  sample_t            audio_out_q, audio_out_d;
  logic               audio_valid_q, audio_valid_d;
  logic               clip_q, clip_d;
  sat_t               s2_sat;

  // S1: multiply by the gain in force before this sample, then step the gain toward its target
  always_comb begin
    cur_gain_d   = cur_gain_q;
    prod_d       = prod_q;
    prod_valid_d = s1_valid;
    eff_target   = bus.mute ? 8'd0 : bus.gain_target;
    target_w     = $signed({2'b00, eff_target});
    gain_up      = $signed({2'b00, cur_gain_q}) + 10'(RAMP_STEP);
    gain_dn      = $signed({2'b00, cur_gain_q}) - 10'(RAMP_STEP);
    if (s1_valid) begin
      prod_d = s1_in * $signed({1'b0, cur_gain_q});
      if (cur_gain_q < eff_target) begin
        cur_gain_d = (gain_up > target_w) ? eff_target : gain_up[7:0];
      end else if (cur_gain_q > eff_target) begin
        cur_gain_d = (gain_dn < target_w) ? eff_target : gain_dn[7:0];
      end
    end
  end

  // S2: drop the unity scaling, clamp to 16 bits and publish the sample
  always_comb begin
    s2_sat        = sat16(prod_q >>> 7);
    audio_out_d   = audio_out_q;
    audio_valid_d = prod_valid_q;
    clip_d        = prod_valid_q & s2_sat.clip;
    if (prod_valid_q) audio_out_d = s2_sat.value;
  end

  // Pipeline and gain registers; reset discards any sample in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_gain_q    <= '0;
      prod_q        <= '0;
      prod_valid_q  <= 1'b0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      clip_q        <= 1'b0;
    end else begin
      cur_gain_q    <= cur_gain_d;
      prod_q        <= prod_d;
      prod_valid_q  <= prod_valid_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      clip_q        <= clip_d;
    end
  end

  logic [7:0] peak_level_w;
  logic       clip_led_w;

  level_meter #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_SHIFT  (DECAY_SHIFT),
    .CLIP_HOLD    (CLIP_HOLD)
  ) u_level_meter (
    .clk         (clk),
    .reset       (reset),
    .audio_out   (audio_out_q),
    .audio_valid (audio_valid_q),
    .clip        (clip_q),
    .peak_level  (peak_level_w),
    .clip_led    (clip_led_w)
  );

  assign bus.audio_out   = audio_out_q;
  assign bus.audio_valid = audio_valid_q;
  assign bus.peak_level  = peak_level_w;
  assign bus.clip_led    = clip_led_w;

endmodule

// File: tb/tb_audio_output_stage.sv
// tb/tb_audio_output_stage.sv - directed self-checking bench for audio_output_stage
module tb_audio_output_stage;
  import audio_pkg::*;

  localparam int HOLD_SAMPLES = 4800;
  localparam int CLIP_HOLD    = 24000;
`ifdef AUDIO_OUTPUT_STAGE_DC_BLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   last_lat;

  audio_output_stage_if bus();

  audio_output_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_audio_out"}, int'(bus.audio_out), 0);
    check({tag, "_audio_valid"}, int'(bus.audio_valid), 0);
    check({tag, "_clip_led"}, int'(bus.clip_led), 0);
    check({tag, "_peak_level"}, int'(bus.peak_level), 0);
  endtask

  // One strobe, wait (bounded) for its output, then one extra cycle so the meter has absorbed it
  task automatic send(input int s, output int got);
    bus.sample_in    = sample_t'(s);
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    last_lat = 1;
    while (!bus.audio_valid && last_lat < 8) begin
      @(posedge clk); #1;
      last_lat++;
    end
    if (!bus.audio_valid) check("valid_timeout", 0, 1);
    got = int'(bus.audio_out);
    @(posedge clk); #1;
  endtask

  // Back-to-back strobes of one value, then let the pipeline drain
  task automatic burst(input int s, input int n);
    bus.sample_in    = sample_t'(s);
    bus.sample_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int got;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.gain_target  = UNITY_GAIN;
    bus.mute         = 1'b0;
    do_reset();
    check_idle("reset");

`ifdef AUDIO_OUTPUT_STAGE_DC_BLOCK_EN
    burst(0, 128);
    send(8000, got);
    check("dc_latency", last_lat, LAT);
    check("dc_first", got, 8000);
    send(8000, got);
    check("dc_second", got, 7969);
    burst(8000, 2000);
    send(8000, got);
    check("dc_decayed", int'(got >= 0 && got < 256), 1);
`else
    // Fade-in from silence at unity target
    for (int n = 0; n < 130; n++) begin
      send(1000, got);
      if (n == 0) check("latency", last_lat, LAT);
      check($sformatf("fadein_%0d", n), got, (1000 * ((n < 128) ? n : 128)) / 128);
    end

    // Full-scale back-to-back samples at unity gain
    begin
      int outs[$];
      int idx[$];
      for (int c = 0; c < 6; c++) begin
        bus.sample_valid = (c < 3);
        bus.sample_in    = (c == 0) ? SAMPLE_MIN : (c == 1) ? SAMPLE_MAX : 16'sd5;
        @(posedge clk); #1;
        if (bus.audio_valid) begin
          outs.push_back(int'(bus.audio_out));
          idx.push_back(c);
        end
      end
      check("b2b_count", outs.size(), 3);
      if (outs.size() == 3) begin
        check("b2b_0", outs[0], -32768);
        check("b2b_1", outs[1], 32767);
        check("b2b_2", outs[2], 5);
        check("b2b_span", idx[2] - idx[0], 2);
      end
      check("b2b_noclip", int'(bus.clip_led), 0);
    end

    // Clipping at maximum gain and clip-led stretch
    bus.gain_target = 8'd255;
    burst(0, 127);
    send(-20000, got);
    check("clip_neg", got, -32768);
    check("clip_neg_led", int'(bus.clip_led), 1);
    send(20000, got);
    check("clip_pos", got, 32767);
    check("clip_pos_led", int'(bus.clip_led), 1);
    check("clip_peak", int'(bus.peak_level), 255);
    burst(0, CLIP_HOLD - 1);
    check("clip_held", int'(bus.clip_led), 1);
    send(0, got);
    check("clip_expired", int'(bus.clip_led), 0);

    // Mute fade-out and ramp back up without overshoot
    bus.gain_target = UNITY_GAIN;
    burst(0, 127);
    bus.mute = 1'b1;
    burst(1000, 128);
    send(1000, got);
    check("muted", got, 0);
    bus.mute = 1'b0;
    for (int j = 0; j < 200; j++) begin
      send(1000, got);
      check($sformatf("unmute_%0d", j), got, (1000 * ((j < 128) ? j : 128)) / 128);
    end

    // Peak hold then decay to zero
    do_reset();
    check_idle("reset2");
    burst(0, 128);
    send(16384, got);
    check("peak_sample", got, 16384);
    check("peak_set", int'(bus.peak_level), 128);
    burst(0, HOLD_SAMPLES);
    check("peak_hold_end", int'(bus.peak_level), 128);
    send(0, got);
    check("peak_first_decay", int'(bus.peak_level), 126);
    begin
      int prev;
      int mono;
      prev = 126;
      mono = 1;
      for (int k = 0; k < 600; k++) begin
        send(0, got);
        if (int'(bus.peak_level) > prev) mono = 0;
        prev = int'(bus.peak_level);
      end
      check("peak_monotonic", mono, 1);
      check("peak_zero", int'(bus.peak_level), 0);
    end

    // Reset one cycle after a strobe discards the sample
    send(1000, got);
    check("pre_reset_out", got, 1000);
    bus.sample_in    = 16'sd1000;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (bus.audio_valid) seen++;
        @(posedge clk); #1;
      end
      check("midreset_valids", seen, 0);
    end
    check_idle("midreset");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
